// File: rtl/md_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide controller.
interface md_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        id_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs_data, rt_data, flush, id_is_md,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  start, md_op, rs_data, rt_data, flush, id_is_md,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// MIPS multiply/divide controller: owns HI/LO, sequences MULT/DIV latency, drives md_stall.
// Define MD_MADD_EN to enable md_op 6/7 as signed madd/msub accumulating into HI/LO.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        busy_r;
  logic [31:0] hi_r, lo_r, hi_n, lo_n;

  logic [31:0] a, b;
  logic [2:0]  op;
  logic        is_long, is_mul;

  assign a  = md.rs_data;
  assign b  = md.rt_data;
  assign op = md.md_op;

  always_comb begin
    is_long = ~op[2];
    is_mul  = (op[2:1] == 2'b00);
`ifdef MD_MADD_EN
    if (op[2:1] == 2'b11) begin
      is_long = 1'b1;
      is_mul  = 1'b1;
    end
`endif
  end

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider shared by div/divu; signed div works on magnitudes.
  logic        a_neg, b_neg;
  logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;
  always_comb begin
    a_neg = (op == 3'd2) & a[31];
    b_neg = (op == 3'd2) & b[31];
    dvd   = a_neg ? -a : a;
    dvs   = (b == 32'd0) ? 32'd1 : (b_neg ? -b : b);
    q_mag = dvd / dvs;
    r_mag = dvd % dvs;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  logic [63:0] res;
  always_comb begin
    res = 64'd0;
    case (op)
      3'd0: res = prod_s;
      3'd1: res = prod_u;
      3'd2, 3'd3: res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
`ifdef MD_MADD_EN
      3'd6: res = {hi_r, lo_r} + prod_s;
      3'd7: res = {hi_r, lo_r} - prod_s;
`endif
      default: res = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      cnt    <= 5'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      hi_n   <= 32'd0;
      lo_n   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // flush in the same cycle suppresses both long ops and mthi/mtlo
          if (md.start && !md.flush) begin
            if (is_long) begin
              hi_n   <= res[63:32];
              lo_n   <= res[31:0];
              cnt    <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
              busy_r <= 1'b1;
              state  <= RUN;
            end else if (op == 3'd4) begin
              hi_r <= a;
            end else if (op == 3'd5) begin
              lo_r <= a;
            end
          end
        end
        RUN: begin
          if (md.flush) begin
            cnt    <= 5'd0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
              hi_r   <= hi_n;
              lo_r   <= lo_n;
              busy_r <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign md.busy     = busy_r;
  assign md.hi       = hi_r;
  assign md.lo       = lo_r;
  assign md.md_stall = md.id_is_md & (busy_r | (md.start & is_long));
endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: driver pushes expected HI/LO/latency, monitor checks on busy fall.
module tb_md_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_if md ();
  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(md));

  typedef struct { logic [31:0] hi; logic [31:0] lo; int len; } exp_t;
  exp_t scb[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op <= 3'd3) || (op >= 3'd6);
`else
    return op <= 3'd3;
`endif
  endfunction

  function automatic int op_len(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? DC : MC;
  endfunction

  // Reference arithmetic straight from the ISA definitions using 64-bit integers.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, b, h, l);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'd6: return {h, l} + 64'(sa * sb);
      3'd7: return {h, l} - 64'(sa * sb);
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic idm, input int fl_at);
    bit lng;
    int len;
    logic [63:0] r;
    exp_t e;
    lng = is_long(op);
    len = op_len(op);
    @(negedge clk);
    md.start = 1'b1; md.md_op = op; md.rs_data = a; md.rt_data = b;
    md.id_is_md = idm; md.flush = 1'b0;
    #1 chk("stall_start", 32'(md.md_stall), 32'(idm & lng));
    @(posedge clk);
    r = ref_res(op, a, b, mhi, mlo);
    if (lng) begin
      e.hi = r[63:32]; e.lo = r[31:0]; e.len = len;
      scb.push_back(e);
    end else if (op == 3'd4) mhi = a;
    else if (op == 3'd5) mlo = a;
    @(negedge clk);
    md.start = 1'b0; md.rs_data = $urandom; md.rt_data = $urandom;
    if (!lng) begin
      #1;
      chk("hi_imm", md.hi, mhi);
      chk("lo_imm", md.lo, mlo);
      chk("busy_imm", 32'(md.busy), 32'd0);
    end else begin
      bit flushed = 1'b0;
      for (int c = 1; c <= len; c++) begin
        if (c > 1) @(negedge clk);
        #1 chk("stall_busy", 32'(md.md_stall), 32'(idm));
        if (c == fl_at) begin
          md.flush = 1'b1;
          @(posedge clk);
          e.hi = mhi; e.lo = mlo; e.len = c;
          void'(scb.pop_back());
          scb.push_back(e);
          @(negedge clk);
          md.flush = 1'b0;
          flushed = 1'b1;
          break;
        end
      end
      if (!flushed) begin
        @(posedge clk);
        mhi = r[63:32]; mlo = r[31:0];
        @(negedge clk);
      end
      #1;
      chk("stall_after", 32'(md.md_stall), 32'd0);
      chk("busy_after", 32'(md.busy), 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles and checks each completed operation against the scoreboard.
  initial begin
    int cnt = 0;
    bit pb = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (md.busy) cnt++;
        else if (pb) begin
          if (scb.size() == 0) begin
            total++; bad++;
            $display("FAIL scb_empty actual=commit expected=none t=%0t", $time);
          end else begin
            e = scb.pop_front();
            chk("commit_hi", md.hi, e.hi);
            chk("commit_lo", md.lo, e.lo);
            chk("busy_len", 32'(cnt), 32'(e.len));
          end
          cnt = 0;
        end
        pb = md.busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    md.start = 1'b0; md.md_op = 3'd0; md.rs_data = 32'd0; md.rt_data = 32'd0;
    md.flush = 1'b0; md.id_is_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(md.busy), 32'd0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);

    // async reset three cycles into a div
    @(negedge clk); md.start = 1'b1; md.md_op = 3'd4; md.rs_data = 32'h55;
    @(negedge clk); md.md_op = 3'd2; md.rs_data = 32'd100; md.rt_data = 32'd3;
    @(negedge clk); md.start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", 32'(md.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(md.busy), 32'd0);
    chk("midrst_hi", md.hi, 32'd0);
    chk("midrst_lo", md.lo, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("postrst_hi", md.hi, 32'd0);
    chk("postrst_lo", md.lo, 32'd0);
    chk("postrst_busy", 32'(md.busy), 32'd0);
    mhi = 32'd0; mlo = 32'd0;
    mon_en = 1'b1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
    chk("mult_hi", md.hi, 32'hFFFF_FFFF);
    chk("mult_lo", md.lo, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
    chk("multu_hi", md.hi, 32'h0000_0002);
    chk("multu_lo", md.lo, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    chk("div_hi", md.hi, 32'hFFFF_FFFF);
    chk("div_lo", md.lo, 32'hFFFF_FFFD);
    issue(3'd3, 32'd7, 32'd0, 1'b0, 0);
    chk("divu0_hi", md.hi, 32'd7);
    chk("divu0_lo", md.lo, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("divovf_hi", md.hi, 32'd0);
    chk("divovf_lo", md.lo, 32'h8000_0000);

    issue(3'd4, 32'h1234, 32'd0, 1'b0, 0);
    issue(3'd5, 32'h5678, 32'd0, 1'b0, 0);
    chk("mthi_hi", md.hi, 32'h1234);
    chk("mtlo_lo", md.lo, 32'h5678);

    // flush and start together in IDLE: nothing happens
    @(negedge clk);
    md.start = 1'b1; md.md_op = 3'd4; md.rs_data = 32'hDEAD; md.flush = 1'b1; md.id_is_md = 1'b0;
    @(negedge clk); md.md_op = 3'd2;
    @(negedge clk); md.start = 1'b0; md.flush = 1'b0;
    #1;
    chk("fl_mthi_hi", md.hi, 32'h1234);
    chk("fl_div_busy", 32'(md.busy), 32'd0);

    issue(3'd4, 32'hA, 32'd0, 1'b0, 0);
    issue(3'd5, 32'hB, 32'd0, 1'b0, 0);
    issue(3'd2, 32'd100, 32'd7, 1'b1, 4);
    chk("flush_hi", md.hi, 32'hA);
    chk("flush_lo", md.lo, 32'hB);

`ifdef MD_MADD_EN
    issue(3'd4, 32'd0, 32'd0, 1'b0, 0);
    issue(3'd5, 32'd5, 32'd0, 1'b0, 0);
    issue(3'd6, 32'd2, 32'd3, 1'b1, 0);
    chk("madd_hi", md.hi, 32'd0);
    chk("madd_lo", md.lo, 32'd11);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      int fl;
      op = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, op_len(op)) : 0;
      issue(op, pick(), pick(), 1'($urandom_range(0, 1)), fl);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scb_drain", 32'(scb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
